// File: rtl/alu_exec_unit.sv
// alu_exec_unit: execute stage behind ALUControl. Logic/arithmetic ops
// finish at the accept edge. Shifts iterate one bit position per cycle
// through the result register. There is a valid/ready handshake on both sides.
module alu_exec_unit #(
    parameter  int WIDTH = 32,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       alu_control,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             illegal
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_XOR  = 4'b0011;
    localparam logic [3:0] OP_SLL  = 4'b0100;
    localparam logic [3:0] OP_SRL  = 4'b0101;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_SLTU = 4'b1000;
    localparam logic [3:0] OP_SRA  = 4'b1101;

    // The shift kind is stored as {code[3], code[0]}: SLL=00, SRL=01, SRA=11.
    localparam logic [1:0] SK_SLL = 2'b00;
    localparam logic [1:0] SK_SRL = 2'b01;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             illegal_q, illegal_d;
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic [1:0]       shk_q, shk_d;

    logic [WIDTH-1:0] alu_res;
    logic             alu_legal;
    logic             is_shift;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] shifted;

    assign shamt = b[SHW-1:0];

    // Single-cycle ALU result and the legality decode of the incoming code.
    always_comb begin
        alu_res   = '0;
        alu_legal = 1'b1;
        is_shift  = 1'b0;
        case (alu_control)
            OP_AND:  alu_res = a & b;
            OP_OR:   alu_res = a | b;
            OP_ADD:  alu_res = a + b;
            OP_SUB:  alu_res = a - b;
            OP_XOR:  alu_res = a ^ b;
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
            OP_SLL, OP_SRL, OP_SRA: begin
                alu_res  = a;   // a shift by zero returns a unchanged
                is_shift = 1'b1;
            end
            default: begin
                alu_res   = '0;
                alu_legal = 1'b0;
            end
        endcase
    end

    // One bit position of the working value per SHIFT cycle.
    always_comb begin
        case (shk_q)
            SK_SLL:  shifted = {result_q[WIDTH-2:0], 1'b0};
            SK_SRL:  shifted = {1'b0, result_q[WIDTH-1:1]};
            default: shifted = {result_q[WIDTH-1], result_q[WIDTH-1:1]};
        endcase
    end

    // Next-state logic. The result register is the shift working register, too.
    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        zero_d    = zero_q;
        illegal_d = illegal_q;
        cnt_d     = cnt_q;
        shk_d     = shk_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    if (is_shift && (shamt != '0)) begin
                        result_d  = a;
                        zero_d    = (a == '0);
                        illegal_d = 1'b0;
                        cnt_d     = shamt;
                        shk_d     = {alu_control[3], alu_control[0]};
                        state_d   = S_SHIFT;
                    end else begin
                        result_d  = alu_res;
                        zero_d    = (alu_res == '0);
                        illegal_d = ~alu_legal;
                        state_d   = S_DONE;
                    end
                end
            end
            S_SHIFT: begin
                result_d = shifted;
                zero_d   = (shifted == '0);
                cnt_d    = cnt_q - 1'b1;
                if (cnt_q == {{(SHW-1){1'b0}}, 1'b1}) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers. Reset aborts any op in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            result_q  <= '0;
            zero_q    <= 1'b0;
            illegal_q <= 1'b0;
            cnt_q     <= '0;
            shk_q     <= SK_SLL;
        end else begin
            state_q   <= state_d;
            result_q  <= result_d;
            zero_q    <= zero_d;
            illegal_q <= illegal_d;
            cnt_q     <= cnt_d;
            shk_q     <= shk_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign result    = result_q;
    assign zero      = zero_q;
    assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit: the driver pushes expected responses,
// and a monitor pops and compares each one when out_valid rises.
module tb_alu_exec_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  alu_control = 4'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] result;
    logic        zero;
    logic        illegal;

    alu_exec_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .alu_control(alu_control), .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .zero(zero), .illegal(illegal)
    );

    always #5 clk = ~clk;

    // Number of rising edges seen. After edge k it reads k.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] r;
        logic        z;
        logic        il;
        int          lat;   // edges after the accept edge until out_valid rises
        int          acc;   // edge number of the accept edge
        string       name;
    } exp_t;

    exp_t sb[$];
    int total = 0;
    int bad   = 0;
    int txn   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got=0x%08h want=0x%08h", name, act, req);
        end
    endtask

    // Monitor: compare each newly presented result against the scoreboard head.
    logic prev_ov = 1'b0;
    always @(negedge clk) begin
        if (out_valid && !prev_ov) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_out: got out_valid=1 result=0x%08h want no output", result);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check({e.name, "_result"}, result, e.r);
                check({e.name, "_zero"}, {31'b0, zero}, {31'b0, e.z});
                check({e.name, "_illegal"}, {31'b0, illegal}, {31'b0, e.il});
                check({e.name, "_latency"}, cyc - e.acc, e.lat);
                txn++;
                $display("txn %0d %s: result=0x%08h zero=%0b illegal=%0b latency=%0d",
                         txn, e.name, result, zero, illegal, cyc - e.acc);
            end
        end
        prev_ov <= out_valid;
    end

    // Issue one op and record its expected response. in_ready depends only on
    // state, so seeing it high at the falling edge means the next rising edge accepts.
    task automatic issue(input string name, input logic [3:0] code, input logic [31:0] av,
                         input logic [31:0] bv, input logic [31:0] er, input logic ez,
                         input logic eil, input int lat);
        exp_t e;
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            total++;
            bad++;
            $display("FAIL %s_accept_timeout: got in_ready=0 want 1", name);
        end else begin
            alu_control = code;
            a           = av;
            b           = bv;
            in_valid    = 1'b1;
            e.r = er; e.z = ez; e.il = eil; e.lat = lat; e.acc = cyc + 1; e.name = name;
            sb.push_back(e);
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            a        = $urandom;
            b        = $urandom;
        end
    endtask

    // Wait, with a bound, until the scoreboard is drained.
    task automatic drain(input string name);
        int n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL %s_drain_timeout: got pending=%0d want 0", name, sb.size());
            sb.delete();
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check("rst_in_ready", {31'b0, in_ready}, 32'd1);
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_zero", {31'b0, zero}, 32'd0);
        check("rst_illegal", {31'b0, illegal}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", {31'b0, in_ready}, 32'd1);

        // Directed vectors. Latency is counted in edges after the accept edge.
        // Non-shift results are visible right after the accept edge.
        issue("add",    4'b0010, 32'd5,          32'd7,          32'd12,         1'b0, 1'b0, 0);  drain("add");
        issue("sub0",   4'b0110, 32'd7,          32'd7,          32'd0,          1'b1, 1'b0, 0);  drain("sub0");
        issue("subwr",  4'b0110, 32'd0,          32'd1,          32'hFFFF_FFFF,  1'b0, 1'b0, 0);  drain("subwr");
        issue("srl4",   4'b0101, 32'h8000_0000,  32'd4,          32'h0800_0000,  1'b0, 1'b0, 4);  drain("srl4");
        issue("sra4",   4'b1101, 32'h8000_0000,  32'd4,          32'hF800_0000,  1'b0, 1'b0, 4);  drain("sra4");
        issue("sra3p",  4'b1101, 32'h4000_0000,  32'd3,          32'h0800_0000,  1'b0, 1'b0, 3);  drain("sra3p");
        issue("sll31",  4'b0100, 32'd1,          32'd31,         32'h8000_0000,  1'b0, 1'b0, 31); drain("sll31");
        issue("sll0",   4'b0100, 32'h0000_1234,  32'h0000_0020,  32'h0000_1234,  1'b0, 1'b0, 0);  drain("sll0");
        issue("xor",    4'b0011, 32'h0000_F0F0,  32'h0000_0FF0,  32'h0000_FF00,  1'b0, 1'b0, 0);  drain("xor");
        issue("and",    4'b0000, 32'hFF00_FF00,  32'h0F0F_0F0F,  32'h0F00_0F00,  1'b0, 1'b0, 0);  drain("and");
        issue("or",     4'b0001, 32'hFF00_FF00,  32'h0F0F_0F0F,  32'hFF0F_FF0F,  1'b0, 1'b0, 0);  drain("or");
        issue("slt",    4'b0111, 32'hFFFF_FFFF,  32'd1,          32'd1,          1'b0, 1'b0, 0);  drain("slt");
        issue("sltu",   4'b1000, 32'hFFFF_FFFF,  32'd1,          32'd0,          1'b1, 1'b0, 0);  drain("sltu");
        issue("ill",    4'b1111, 32'h1234_5678,  32'h9ABC_DEF0,  32'd0,          1'b1, 1'b1, 0);  drain("ill");

        // Backpressure: result held in DONE while a new op waits upstream.
        out_ready = 1'b0;
        issue("bp_add", 4'b0010, 32'd3, 32'd4, 32'd7, 1'b0, 1'b0, 0);
        drain("bp_add");
        alu_control = 4'b0010;
        a           = 32'd100;
        b           = 32'd1;
        in_valid    = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_result", result, 32'd7);
            check("bp_out_valid", {31'b0, out_valid}, 32'd1);
            check("bp_in_ready", {31'b0, in_ready}, 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_pop_out_valid", {31'b0, out_valid}, 32'd0);
        check("bp_pop_in_ready", {31'b0, in_ready}, 32'd1);
        repeat (3) @(negedge clk);

        // Abort: reset in the middle of an SLL by 20 must not produce any output.
        alu_control = 4'b0100;
        a           = 32'd1;
        b           = 32'd20;
        in_valid    = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("abort_busy", {31'b0, in_ready}, 32'd0);
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_in_ready", {31'b0, in_ready}, 32'd1);
        check("abort_out_valid", {31'b0, out_valid}, 32'd0);
        check("abort_result", result, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            check("abort_no_output", {31'b0, out_valid}, 32'd0);
        end

        // The stage still works after the abort.
        issue("post_abort_add", 4'b0010, 32'hFFFF_FFFF, 32'd2, 32'd1, 1'b0, 1'b0, 0);
        drain("post_abort_add");
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
